// File: rtl/mips_ctrl_pkg.sv
// Shared state encoding, opcode values and datapath select constants
// for the multi-cycle MIPS control sequencer.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        WB_ALU,
        WB_MEM,
        BRANCH,
        TRAP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
    localparam logic [1:0] ALU_SRC_B_BRANCH = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access and flags a
// timeout once MAX_WAIT of them have gone by with the access still pending.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic timeout
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] count;

    // Saturates at the limit so it never wraps back under the timeout compare.
    always_ff @(posedge clk) begin
        if (reset || !active || ready) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = active && !ready && (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: datapath controls are decoded from the
// state register; traps stickily on an illegal opcode or a memory timeout.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                pc_source,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_half,
    output logic                mem_signed,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                illegal_op,
    output logic                bus_err,
    output logic                halted,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          dbgState
);
    state_e              state;
    logic [OPCODE_W-1:0] opQ;
    logic                illegalQ;
    logic                busErrQ;
    logic [CNT_W-1:0]    retiredQ;
    logic                memPhase;
    logic                timeout;
    logic                isRtype;
    logic                isStore;
    logic                isHalf;
    logic                isSigned;
    logic                isMemOp;

    // Handshake: mem_read/mem_write stay asserted for the whole memory state;
    // the access completes in the cycle mem_ready is high and the FSM advances.
    assign memPhase = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

    assign isRtype  = (opQ == OPCODE_W'(OP_RTYPE));
    assign isStore  = (opQ == OPCODE_W'(OP_SW));
    assign isSigned = (opQ == OPCODE_W'(OP_LH));
    assign isHalf   = isSigned || (opQ == OPCODE_W'(OP_LHU));
    assign isMemOp  = (opcode == OPCODE_W'(OP_LW)) || (opcode == OPCODE_W'(OP_SW)) ||
                      (opcode == OPCODE_W'(OP_LH)) || (opcode == OPCODE_W'(OP_LHU));

    mem_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) waitTimer (
        .clk    (clk),
        .reset  (reset),
        .active (memPhase),
        .ready  (mem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            opQ      <= '0;
            illegalQ <= 1'b0;
            busErrQ  <= 1'b0;
            retiredQ <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        state <= DECODE;
                    end else if (timeout) begin
                        state   <= TRAP;
                        busErrQ <= 1'b1;
                    end
                end
                DECODE: begin
                    opQ <= opcode;
                    if (opcode == OPCODE_W'(OP_RTYPE)) begin
                        state <= EXEC_R;
                    end else if (opcode == OPCODE_W'(OP_ADDI)) begin
                        state <= EXEC_I;
                    end else if (isMemOp) begin
                        state <= MEM_ADDR;
                    end else if (opcode == OPCODE_W'(OP_BEQ)) begin
                        state <= BRANCH;
                    end else begin
                        state    <= TRAP;
                        illegalQ <= 1'b1;
                    end
                end
                EXEC_R, EXEC_I: state <= WB_ALU;
                MEM_ADDR:       state <= isStore ? MEM_WR : MEM_RD;
                MEM_RD: begin
                    if (mem_ready) begin
                        state <= WB_MEM;
                    end else if (timeout) begin
                        state   <= TRAP;
                        busErrQ <= 1'b1;
                    end
                end
                MEM_WR: begin
                    if (mem_ready) begin
                        state    <= FETCH;
                        retiredQ <= retiredQ + CNT_W'(1);
                    end else if (timeout) begin
                        state   <= TRAP;
                        busErrQ <= 1'b1;
                    end
                end
                WB_ALU, WB_MEM, BRANCH: begin
                    state    <= FETCH;
                    retiredQ <= retiredQ + CNT_W'(1);
                end
                TRAP:    state <= TRAP;
                default: state <= TRAP;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_half      = 1'b0;
        mem_signed    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALU_SRC_B_REG;
        alu_op        = ALU_OP_ADD;
        illegal_op    = 1'b0;
        bus_err       = 1'b0;
        halted        = 1'b0;
        retired       = '0;
        dbgState      = '0;
        // Everything reads as zero while reset is held, whatever the state register holds.
        if (!reset) begin
            illegal_op = illegalQ;
            bus_err    = busErrQ;
            retired    = retiredQ;
            dbgState   = state;
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALU_SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: alu_src_b = ALU_SRC_B_BRANCH;
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_FUNCT;
                end
                EXEC_I, MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_SRC_B_IMM;
                end
                WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = isRtype;
                end
                MEM_RD: begin
                    mem_read   = 1'b1;
                    i_or_d     = 1'b1;
                    mem_half   = isHalf;
                    mem_signed = isSigned;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    mem_half   = isHalf;
                    mem_signed = isSigned;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_OP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 1'b1;
                end
                TRAP:    halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table-driven instruction runs plus hand-built reset,
// trap and timeout sequences, each cycle's control word checked against an expected queue.
`timescale 1ns/1ps
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    localparam int W = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
    logic        mem_half, mem_signed, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        illegal_op, bus_err, halted;
    logic [31:0] retired;
    logic [3:0]  dbgState;
    logic [W-1:0] actW;

    typedef struct {
        logic [5:0] op;
        int         fWait;
        int         mWait;
        logic       half;
        logic       sgn;
        logic       rdst;
    } vec_t;

    typedef struct {
        logic       rdy;
        logic [5:0] op;
    } drv_t;

    logic [W-1:0] exp_q[$];
    drv_t         drv_q[$];
    vec_t         tbl[12];
    int           nCompared = 0;
    int           nMismatched = 0;
    logic [31:0]  expRetired = '0;
    logic [W-1:0] wFetchWait, wFetchGo, wDecode, wExecR, wExecI, wMemAddr, wMemWr, wBranch;

    always #5 clk = ~clk;

    multicycle_control #(.OPCODE_W(6), .CNT_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_half(mem_half), .mem_signed(mem_signed), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal_op(illegal_op), .bus_err(bus_err), .halted(halted),
        .retired(retired), .dbgState(dbgState)
    );

    assign actW = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                   mem_half, mem_signed, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, alu_op, illegal_op, bus_err, halted};

    function automatic logic [W-1:0] mkw(
        input logic pcW, pcWC, pcS, iod, mr, mw, mh, ms, irW, rd, m2r, rw, sa,
        input logic [1:0] sb, aop, input logic ill, be, hlt);
        return {pcW, pcWC, pcS, iod, mr, mw, mh, ms, irW, rd, m2r, rw, sa, sb, aop, ill, be, hlt};
    endfunction

    function automatic logic [W-1:0] wbAluW(input logic rd);
        return mkw(0,0,0,0,0,0,0,0,0,rd,0,1,0,2'b00,2'b00,0,0,0);
    endfunction
    function automatic logic [W-1:0] memRdW(input logic h, s);
        return mkw(0,0,0,1,1,0,h,s,0,0,0,0,0,2'b00,2'b00,0,0,0);
    endfunction
    function automatic logic [W-1:0] wbMemW(input logic h, s);
        return mkw(0,0,0,0,0,0,h,s,0,0,1,1,0,2'b00,2'b00,0,0,0);
    endfunction
    function automatic logic [W-1:0] trapW(input logic ill, be);
        return mkw(0,0,0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,ill,be,1);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction
    function automatic logic [5:0] junk();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w, input logic rdy, input logic [5:0] op);
        drv_t d;
        d.rdy = rdy;
        d.op  = op;
        exp_q.push_back(w);
        drv_q.push_back(d);
    endtask

    // Drives one queued cycle at a time, compares mid-cycle, returns just after the next edge.
    task automatic drain(input string tag);
        int n = 0;
        while (drv_q.size() > 0) begin
            drv_t d;
            logic [W-1:0] e;
            d = drv_q.pop_front();
            e = exp_q.pop_front();
            mem_ready = d.rdy;
            opcode    = d.op;
            @(negedge clk);
            checkVal($sformatf("%s cyc%0d ctrl", tag, n), 32'(actW), 32'(e));
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic resetFor(input int n);
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = junk();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkVal($sformatf("reset cyc%0d ctrl", i), 32'(actW), 32'd0);
            checkVal($sformatf("reset cyc%0d retired", i), retired, 32'd0);
            @(posedge clk);
            #1;
        end
        reset      = 1'b0;
        expRetired = '0;
    endtask

    task automatic buildInstr(input vec_t v);
        for (int i = 0; i < v.fWait; i++) push(wFetchWait, 1'b0, v.op);
        push(wFetchGo, 1'b1, v.op);
        push(wDecode, rbit(), v.op);
        case (v.op)
            6'h00: begin
                push(wExecR, rbit(), junk());
                push(wbAluW(v.rdst), rbit(), junk());
            end
            6'h08: begin
                push(wExecI, rbit(), junk());
                push(wbAluW(v.rdst), rbit(), junk());
            end
            6'h23, 6'h21, 6'h25: begin
                push(wMemAddr, rbit(), junk());
                for (int i = 0; i < v.mWait; i++) push(memRdW(v.half, v.sgn), 1'b0, junk());
                push(memRdW(v.half, v.sgn), 1'b1, junk());
                push(wbMemW(v.half, v.sgn), rbit(), junk());
            end
            6'h2B: begin
                push(wMemAddr, rbit(), junk());
                for (int i = 0; i < v.mWait; i++) push(wMemWr, 1'b0, junk());
                push(wMemWr, 1'b1, junk());
            end
            default: push(wBranch, rbit(), junk());
        endcase
    endtask

    task automatic runVec(input vec_t v, input string tag);
        buildInstr(v);
        drain(tag);
        expRetired++;
        checkVal({tag, " retired"}, retired, expRetired);
        checkVal({tag, " back in FETCH"}, 32'(dbgState), 32'(FETCH));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish after 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        wFetchWait = mkw(0,0,0,0,1,0,0,0,0,0,0,0,0,2'b01,2'b00,0,0,0);
        wFetchGo   = mkw(1,0,0,0,1,0,0,0,1,0,0,0,0,2'b01,2'b00,0,0,0);
        wDecode    = mkw(0,0,0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0,0);
        wExecR     = mkw(0,0,0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,0);
        wExecI     = mkw(0,0,0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,0);
        wMemAddr   = mkw(0,0,0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,0);
        wMemWr     = mkw(0,0,0,1,0,1,0,0,0,0,0,0,0,2'b00,2'b00,0,0,0);
        wBranch    = mkw(0,1,1,0,0,0,0,0,0,0,0,0,1,2'b00,2'b01,0,0,0);

        // op, fetch waits, memory waits, expected mem_half, mem_signed, reg_dst
        tbl[0]  = '{6'h00, 0,  0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{6'h08, 0,  0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{6'h23, 0,  2, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{6'h21, 0,  0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{6'h25, 1,  0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{6'h2B, 0,  0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{6'h04, 0,  0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{6'h2B, 0,  3, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{6'h00, 15, 0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{6'h23, 0, 15, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{6'h21, 2,  1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{6'h08, 3,  0, 1'b0, 1'b0, 1'b0};

        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        resetFor(3);
        checkVal("post-reset retired", retired, 32'd0);

        for (int i = 0; i < 12; i++) runVec(tbl[i], $sformatf("vec%0d op%02h", i, tbl[i].op));

        for (int i = 0; i < 8; i++) begin
            v = tbl[$urandom_range(0, 6)];
            v.fWait = $urandom_range(0, 4);
            v.mWait = $urandom_range(0, 4);
            runVec(v, $sformatf("rnd%0d op%02h", i, v.op));
        end

        // Store abandoned by reset while its write is pending: no write, no retire.
        push(wFetchGo, 1'b1, 6'h2B);
        push(wDecode, rbit(), 6'h2B);
        push(wMemAddr, rbit(), junk());
        push(wMemWr, 1'b0, junk());
        push(wMemWr, 1'b0, junk());
        drain("sw abandoned");
        resetFor(1);
        checkVal("abandoned sw retired", retired, 32'd0);
        runVec(tbl[0], "R after abandon");

        // Illegal opcode: trap holds for 20 cycles regardless of inputs.
        push(wFetchGo, 1'b1, 6'h3F);
        push(wDecode, rbit(), 6'h3F);
        for (int i = 0; i < 20; i++) push(trapW(1'b1, 1'b0), rbit(), junk());
        drain("illegal 3F");
        checkVal("illegal retired", retired, expRetired);
        checkVal("illegal in TRAP", 32'(dbgState), 32'(TRAP));
        resetFor(2);

        // Sixteen not-ready cycles in FETCH time out.
        for (int i = 0; i < 16; i++) push(wFetchWait, 1'b0, junk());
        for (int i = 0; i < 3; i++) push(trapW(1'b0, 1'b1), rbit(), junk());
        drain("fetch timeout");
        checkVal("fetch timeout in TRAP", 32'(dbgState), 32'(TRAP));
        resetFor(1);

        // Sixteen not-ready cycles on a load data read time out.
        push(wFetchGo, 1'b1, 6'h23);
        push(wDecode, rbit(), 6'h23);
        push(wMemAddr, rbit(), junk());
        for (int i = 0; i < 16; i++) push(memRdW(1'b0, 1'b0), 1'b0, junk());
        for (int i = 0; i < 2; i++) push(trapW(1'b0, 1'b1), rbit(), junk());
        drain("load timeout");
        checkVal("load timeout retired", retired, 32'd0);
        resetFor(1);
        runVec(tbl[6], "beq after recovery");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
